// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcode and funct3 constants, FSM encoding and the
// request / writeback bundles shared by the memory stage.
package mem_stage_pkg;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;
    localparam logic [6:0] SYS   = 7'b1110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        st;
    } req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// mem_load_ext: picks the addressed byte/halfword lane from the read word
// and sign- or zero-extends it according to funct3.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{addr_lo, 3'b000} +: 8];
    assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Unlisted funct3 encodings fall through to a full-word load.
    assign data = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                  funct3 == F3_BU ? {24'b0, b}       :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_HU ? {16'b0, h}       : rdata;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with a two-state IDLE/ACCESS bus FSM and a
// registered writeback bundle. Define MEM_MISALIGN_CHK_EN to trap misaligned ops.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RES,
    input  logic        EX_MEM_valid,
    input  logic [31:0] EX_MEM_pc,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] EX_MEM_alu,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [31:0] EX_MEM_rs2,
    output logic        MEM_stall,
    output logic        DMEM_req,
    output logic        DMEM_we,
    output logic [31:0] DMEM_addr,
    output logic [3:0]  DMEM_be,
    output logic [31:0] DMEM_wdata,
    input  logic [31:0] DMEM_rdata,
    input  logic        DMEM_ack,
    output logic        MEM_WB_valid,
    output logic [31:0] MEM_WB_pc,
    output logic [31:0] MEM_WB_inst,
    output logic [31:0] MEM_WB_alu,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_data
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic        MEM_misalign
`endif
);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    wb_t         wb_q, wb_d;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        mem_op, misal, is_b, is_h;
    logic [31:0] ld_data;

    assign opc    = EX_MEM_inst[6:0];
    assign f3     = EX_MEM_inst[14:12];
    assign mem_op = EX_MEM_valid && (opc == LCC || opc == SCC);

`ifdef MEM_MISALIGN_CHK_EN
    logic mis_q, mis_d;
    assign misal = mem_op && (f3[1:0] == 2'b01 ? EX_MEM_alu[0] :
                              f3[1:0] != 2'b00 && EX_MEM_alu[1:0] != 2'b00);
    assign MEM_misalign = mis_q;
`else
    assign misal = 1'b0;
`endif

    mem_load_ext u_ext (
        .rdata   (DMEM_rdata),
        .addr_lo (req_q.addr[1:0]),
        .funct3  (req_q.f3),
        .data    (ld_data)
    );

    assign is_b       = req_q.f3[1:0] == 2'b00;
    assign is_h       = req_q.f3[1:0] == 2'b01;
    assign DMEM_req   = state_q == ACCESS;
    assign DMEM_we    = DMEM_req && req_q.st;
    assign DMEM_addr  = {req_q.addr[31:2], 2'b00};
    assign DMEM_be    = is_b ? 4'b0001 << req_q.addr[1:0] :
                        is_h ? (req_q.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign DMEM_wdata = is_b ? {4{req_q.rs2[7:0]}} :
                        is_h ? {2{req_q.rs2[15:0]}} : req_q.rs2;
    assign MEM_stall  = RES && (state_q == IDLE ? mem_op && !misal : !DMEM_ack);

    assign MEM_WB_valid = wb_q.valid;
    assign MEM_WB_pc    = wb_q.pc;
    assign MEM_WB_inst  = wb_q.inst;
    assign MEM_WB_alu   = wb_q.alu;
    assign MEM_WB_rd    = wb_q.rd;
    assign MEM_WB_data  = wb_q.data;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wb_d    = wb_q;
`ifdef MEM_MISALIGN_CHK_EN
        mis_d   = mis_q;
`endif
        if (state_q == IDLE) begin
            if (mem_op && !misal) begin
                state_d  = ACCESS;
                req_d    = '{pc: EX_MEM_pc, inst: EX_MEM_inst, addr: EX_MEM_alu, rs2: EX_MEM_rs2,
                             rd: EX_MEM_rd, f3: f3, st: opc == SCC};
                wb_d.valid = 1'b0;
            end else begin
                // A trapped misaligned op retires immediately without a destination.
                wb_d = '{valid: EX_MEM_valid, pc: EX_MEM_pc, inst: EX_MEM_inst, alu: EX_MEM_alu,
                         data: EX_MEM_alu, rd: misal ? 5'd0 : EX_MEM_rd};
            end
`ifdef MEM_MISALIGN_CHK_EN
            mis_d = misal;
`endif
        end else if (DMEM_ack) begin
            state_d = IDLE;
            wb_d    = '{valid: 1'b1, pc: req_q.pc, inst: req_q.inst, alu: req_q.addr,
                        data: req_q.st ? req_q.addr : ld_data, rd: req_q.st ? 5'd0 : req_q.rd};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            state_q <= IDLE;
            req_q   <= '0;
            wb_q    <= '0;
`ifdef MEM_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
`ifdef MEM_MISALIGN_CHK_EN
            mis_q   <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a writeback scoreboard; a negedge
// monitor pops expected bundles and also checks the retire cycle.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        CLK = 1'b0, RES = 1'b0;
    logic        EX_MEM_valid = 1'b0;
    logic [31:0] EX_MEM_pc = '0, EX_MEM_inst = '0, EX_MEM_alu = '0, EX_MEM_rs2 = '0;
    logic [4:0]  EX_MEM_rd = '0;
    logic [31:0] DMEM_rdata = '0;
    logic        DMEM_ack = 1'b0;
    logic        MEM_stall, DMEM_req, DMEM_we, MEM_WB_valid;
    logic [31:0] DMEM_addr, DMEM_wdata, MEM_WB_pc, MEM_WB_inst, MEM_WB_alu, MEM_WB_data;
    logic [3:0]  DMEM_be;
    logic [4:0]  MEM_WB_rd;
`ifdef MEM_MISALIGN_CHK_EN
    logic        MEM_misalign;
`endif

    mem_stage dut (
        .CLK(CLK), .RES(RES), .EX_MEM_valid(EX_MEM_valid), .EX_MEM_pc(EX_MEM_pc),
        .EX_MEM_inst(EX_MEM_inst), .EX_MEM_alu(EX_MEM_alu), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_rs2(EX_MEM_rs2), .MEM_stall(MEM_stall), .DMEM_req(DMEM_req),
        .DMEM_we(DMEM_we), .DMEM_addr(DMEM_addr), .DMEM_be(DMEM_be),
        .DMEM_wdata(DMEM_wdata), .DMEM_rdata(DMEM_rdata), .DMEM_ack(DMEM_ack),
        .MEM_WB_valid(MEM_WB_valid), .MEM_WB_pc(MEM_WB_pc), .MEM_WB_inst(MEM_WB_inst),
        .MEM_WB_alu(MEM_WB_alu), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_data(MEM_WB_data)
`ifdef MEM_MISALIGN_CHK_EN
        , .MEM_misalign(MEM_misalign)
`endif
    );

    typedef struct {
        logic [31:0] pc, inst, alu, data;
        logic [4:0]  rd;
        logic        mis;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0, fails = 0, cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f, input logic [6:0] op);
        return {17'b0, f, 5'b0, op};
    endfunction

    always @(negedge CLK) begin
        if (RES && MEM_WB_valid) begin
            if (sb.size() == 0) chk("unexpected_wb", {31'b0, MEM_WB_valid}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("wb_pc", MEM_WB_pc, e.pc);
                chk("wb_inst", MEM_WB_inst, e.inst);
                chk("wb_alu", MEM_WB_alu, e.alu);
                chk("wb_rd", {27'b0, MEM_WB_rd}, {27'b0, e.rd});
                chk("wb_data", MEM_WB_data, e.data);
                chk("wb_cycle", cyc, e.due);
`ifdef MEM_MISALIGN_CHK_EN
                chk("wb_misalign", {31'b0, MEM_misalign}, {31'b0, e.mis});
`endif
            end
        end
    end

    // Issue one memory op from IDLE and complete it after w wait cycles.
    task automatic mem_op(input logic [2:0] f, input logic st, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdat, input int w, input logic [31:0] exp_data,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        EX_MEM_valid = 1'b1;
        EX_MEM_pc    = a + 32'h1000;
        EX_MEM_inst  = mk_inst(f, st ? SCC : LCC);
        EX_MEM_alu   = a;
        EX_MEM_rs2   = d;
        EX_MEM_rd    = 5'd7;
        #1;
        chk("issue_stall", {31'b0, MEM_stall}, 32'd1);
        chk("issue_req", {31'b0, DMEM_req}, 32'd0);
        sb.push_back('{EX_MEM_pc, EX_MEM_inst, a, exp_data, st ? 5'd0 : 5'd7, 1'b0, cyc + 2 + w});
        tick();
        EX_MEM_valid = 1'b0;
        repeat (w) begin
            #1;
            chk("wait_stall", {31'b0, MEM_stall}, 32'd1);
            chk("wait_req", {31'b0, DMEM_req}, 32'd1);
            chk("wait_addr", DMEM_addr, a & ~32'd3);
            tick();
        end
        DMEM_ack   = 1'b1;
        DMEM_rdata = rdat;
        #1;
        chk("ack_req", {31'b0, DMEM_req}, 32'd1);
        chk("ack_addr", DMEM_addr, a & ~32'd3);
        chk("ack_we", {31'b0, DMEM_we}, {31'b0, st});
        chk("ack_stall", {31'b0, MEM_stall}, 32'd0);
        if (exp_be != 4'd0) chk("ack_be", {28'b0, DMEM_be}, {28'b0, exp_be});
        if (st) chk("ack_wdata", DMEM_wdata, exp_wd);
        tick();
        DMEM_ack   = 1'b0;
        DMEM_rdata = '0;
        #1;
        chk("post_req", {31'b0, DMEM_req}, 32'd0);
    endtask

    initial begin
        // Reset: a pending memory op must not stall while RES is low.
        tick();
        EX_MEM_valid = 1'b1;
        EX_MEM_inst  = mk_inst(F3_W, LCC);
        #1;
        chk("rst_stall", {31'b0, MEM_stall}, 32'd0);
        tick();
        chk("rst_wb_valid", {31'b0, MEM_WB_valid}, 32'd0);
        chk("rst_wb_data", MEM_WB_data, 32'd0);
        chk("rst_req", {31'b0, DMEM_req}, 32'd0);
        EX_MEM_valid = 1'b0;
        RES = 1'b1;
        tick();

        // Non-memory op passes through with one cycle of latency.
        EX_MEM_valid = 1'b1;
        EX_MEM_pc    = 32'h40;
        EX_MEM_inst  = mk_inst(3'b000, RCC);
        EX_MEM_alu   = 32'h0000_1234;
        EX_MEM_rd    = 5'd5;
        #1;
        chk("rcc_stall", {31'b0, MEM_stall}, 32'd0);
        sb.push_back('{32'h40, EX_MEM_inst, 32'h1234, 32'h1234, 5'd5, 1'b0, cyc + 1});
        tick();
        EX_MEM_pc   = 32'h44;
        EX_MEM_inst = mk_inst(3'b000, MCC);
        EX_MEM_alu  = 32'hCAFE_0001;
        EX_MEM_rd   = 5'd31;
        #1;
        chk("mcc_stall", {31'b0, MEM_stall}, 32'd0);
        sb.push_back('{32'h44, EX_MEM_inst, 32'hCAFE_0001, 32'hCAFE_0001, 5'd31, 1'b0, cyc + 1});
        tick();
        EX_MEM_valid = 1'b0;
        tick();
        chk("bubble_valid", {31'b0, MEM_WB_valid}, 32'd0);

        // Ack while idle must be ignored.
        DMEM_ack = 1'b1;
        #1;
        chk("idle_ack_req", {31'b0, DMEM_req}, 32'd0);
        tick();
        DMEM_ack = 1'b0;
        chk("idle_ack_valid", {31'b0, MEM_WB_valid}, 32'd0);

        mem_op(F3_B,  1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, 32'hFFFF_FF80, 4'd0, 32'h0);
        mem_op(F3_H,  1'b1, 32'h202, 32'h1234_ABCD, 32'h0, 3, 32'h202, 4'b1100, 32'hABCD_ABCD);
        mem_op(F3_H,  1'b0, 32'h10, 32'h0, 32'h1234_8001, 1, 32'hFFFF_8001, 4'd0, 32'h0);
        mem_op(F3_HU, 1'b0, 32'h12, 32'h0, 32'h8001_1234, 0, 32'h0000_8001, 4'd0, 32'h0);
        mem_op(F3_BU, 1'b0, 32'h101, 32'h0, 32'h0000_9A00, 2, 32'h0000_009A, 4'd0, 32'h0);
        mem_op(F3_W,  1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        mem_op(F3_B,  1'b1, 32'h5, 32'h0000_0177, 32'h0, 0, 32'h5, 4'b0010, 32'h7777_7777);
        mem_op(F3_W,  1'b1, 32'h40, 32'h0BAD_F00D, 32'h0, 1, 32'h40, 4'b1111, 32'h0BAD_F00D);

        // Reset during ACCESS abandons the transfer; a late ack is ignored.
        EX_MEM_valid = 1'b1;
        EX_MEM_inst  = mk_inst(F3_W, LCC);
        EX_MEM_alu   = 32'h300;
        EX_MEM_rd    = 5'd3;
        tick();
        EX_MEM_valid = 1'b0;
        #1;
        chk("rsta_req", {31'b0, DMEM_req}, 32'd1);
        RES = 1'b0;
        #1;
        chk("rsta_stall", {31'b0, MEM_stall}, 32'd0);
        tick();
        RES = 1'b1;
        #1;
        chk("rsta_req_after", {31'b0, DMEM_req}, 32'd0);
        chk("rsta_wb_valid", {31'b0, MEM_WB_valid}, 32'd0);
        DMEM_ack = 1'b1;
        #1;
        chk("rsta_ack_stall", {31'b0, MEM_stall}, 32'd0);
        tick();
        DMEM_ack = 1'b0;
        chk("rsta_late_req", {31'b0, DMEM_req}, 32'd0);
        chk("rsta_late_valid", {31'b0, MEM_WB_valid}, 32'd0);

`ifdef MEM_MISALIGN_CHK_EN
        EX_MEM_valid = 1'b1;
        EX_MEM_pc    = 32'h80;
        EX_MEM_inst  = mk_inst(F3_W, LCC);
        EX_MEM_alu   = 32'h3;
        EX_MEM_rd    = 5'd9;
        #1;
        chk("mis_stall", {31'b0, MEM_stall}, 32'd0);
        chk("mis_req", {31'b0, DMEM_req}, 32'd0);
        sb.push_back('{32'h80, EX_MEM_inst, 32'h3, 32'h3, 5'd0, 1'b1, cyc + 1});
        tick();
        EX_MEM_valid = 1'b0;
        chk("mis_req_after", {31'b0, DMEM_req}, 32'd0);
        chk("mis_flag", {31'b0, MEM_misalign}, 32'd1);
        tick();
        chk("mis_flag_clear", {31'b0, MEM_misalign}, 32'd0);
`else
        mem_op(F3_W, 1'b0, 32'h3, 32'h0, 32'h1122_3344, 0, 32'h1122_3344, 4'b1111, 32'h0);
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
